// File: rtl/coef_loader.sv
// Serial coefficient-table loader: packs six bytes per 48-bit word, MSB first, and writes
// DEPTH words to a RAM. A trailing checksum byte is compared with the XOR of all loaded bytes.
module coef_loader #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [47:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        byte_cnt;
  logic [7:0]        csum;
  logic [39:0]       pack;
  logic              xfer, load_xfer, check_xfer, word_end, last_word, restart;

  assign restart    = start && (state == IDLE || state == DONE);
  assign xfer       = byte_valid && byte_ready;
  assign load_xfer  = xfer && (state == LOAD);
  assign check_xfer = xfer && (state == CHECK);
  assign word_end   = load_xfer && (byte_cnt == 3'd5);
  assign last_word  = (addr == LAST_ADDR);

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (word_end && last_word) state_nxt = CHECK;
      CHECK:   if (check_xfer) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == LOAD) || (state == CHECK);
    busy       = (state == LOAD) || (state == CHECK);
    done       = (state == DONE);
  end

  // Partial bytes collect in pack; wr_data/wr_addr only move on a write, so they stay stable between strobes.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      addr     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      pack     <= '0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        addr     <= '0;
        byte_cnt <= '0;
        csum     <= '0;
        err      <= 1'b0;
      end else if (load_xfer) begin
        csum <= csum ^ byte_in;
        if (word_end) begin
          byte_cnt <= '0;
          wr_en    <= 1'b1;
          wr_addr  <= addr;
          wr_data  <= {pack, byte_in};
          if (!last_word) addr <= addr + ADDR_W'(1);
        end else begin
          byte_cnt <= byte_cnt + 3'd1;
          pack     <= {pack[31:0], byte_in};
        end
      end else if (check_xfer) begin
        err <= (byte_in != csum);
      end
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Scoreboard bench for coef_loader: a small-table instance (DEPTH=4) and a default-size instance
// share one clock; a select bit routes stimulus to one of them at a time.
module tb_coef_loader;

  logic        clk = 1'b0;
  logic        RESET, start, byte_valid, sel;
  logic [7:0]  byte_in;

  logic        rdy_s, wr_en_s, busy_s, done_s, err_s;
  logic [1:0]  wr_addr_s;
  logic [47:0] wr_data_s;
  logic        rdy_l, wr_en_l, busy_l, done_l, err_l;
  logic [10:0] wr_addr_l;
  logic [47:0] wr_data_l;
  logic        rdy, start_s, start_l, valid_s, valid_l;

  int          n_chk = 0, n_fail = 0, wcnt_s = 0, wcnt_l = 0;
  logic [63:0] q_s[$], q_l[$];
  logic [7:0]  m_xor, cs;

  assign start_s = start & ~sel;
  assign start_l = start & sel;
  assign valid_s = byte_valid & ~sel;
  assign valid_l = byte_valid & sel;
  assign rdy     = sel ? rdy_l : rdy_s;

  always #5 clk = ~clk;

  coef_loader #(.DEPTH(4), .ADDR_W(2)) dut_s (
    .Fg_CLK(clk), .RESET(RESET), .start(start_s), .byte_in(byte_in), .byte_valid(valid_s),
    .byte_ready(rdy_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .busy(busy_s), .done(done_s), .err(err_s));

  coef_loader dut_l (
    .Fg_CLK(clk), .RESET(RESET), .start(start_l), .byte_in(byte_in), .byte_valid(valid_l),
    .byte_ready(rdy_l), .wr_en(wr_en_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l),
    .busy(busy_l), .done(done_l), .err(err_l));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_s) begin
      wcnt_s++;
      if (q_s.size() == 0) chk("s_unexp_wr", 64'(q_s.size()), 64'd1);
      else chk("s_wr", {14'd0, wr_addr_s, wr_data_s}, q_s.pop_front());
    end
    if (wr_en_l) begin
      wcnt_l++;
      if (q_l.size() == 0) chk("l_unexp_wr", 64'(q_l.size()), 64'd1);
      else chk("l_wr", {5'd0, wr_addr_l, wr_data_l}, q_l.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) chk("rdy_timeout", 64'(rdy), 64'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: bytes 1,2,3,...; mode 1: random. Expected word pushed once its sixth byte is accepted.
  task automatic load_words(input int depth, input int mode, input bit gap,
                            input int stop_after, input int mid_start);
    logic [47:0] w;
    logic [7:0]  b;
    int idx;
    idx = 0;
    m_xor = 8'd0;
    for (int wi = 0; wi < depth; wi++) begin
      w = 48'd0;
      for (int k = 0; k < 6; k++) begin
        b = (mode != 0) ? 8'($urandom) : 8'(idx + 1);
        w[47-8*k -: 8] = b;
        m_xor ^= b;
        if (idx == mid_start) begin
          pulse_start();
          chk("mid_start_busy", 64'(busy_s), 64'd1);
        end
        send_byte(b, gap);
        idx++;
        if (idx == stop_after) return;
      end
      if (sel) q_l.push_back({16'(wi), w});
      else     q_s.push_back({16'(wi), w});
    end
  endtask

  task automatic chk_end(input string tag, input logic exp_err, input int exp_wcnt);
    chk({tag, "_done"}, 64'(done_s), 64'd1);
    chk({tag, "_err"},  64'(err_s), 64'(exp_err));
    chk({tag, "_busy"}, 64'(busy_s), 64'd0);
    chk({tag, "_rdy"},  64'(rdy_s), 64'd0);
    chk({tag, "_wcnt"}, 64'(wcnt_s), 64'(exp_wcnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; RESET = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy",   64'(rdy_s), 64'd0);
    chk("rst_busy",  64'(busy_s), 64'd0);
    chk("rst_done",  64'(done_s), 64'd0);
    chk("rst_err",   64'(err_s), 64'd0);
    chk("rst_wr_en", 64'(wr_en_s), 64'd0);
    chk("rst_addr",  64'(wr_addr_s), 64'd0);
    chk("rst_data",  64'(wr_data_s), 64'd0);

    // Back-to-back load with correct checksum
    pulse_start();
    chk("t1_busy", 64'(busy_s), 64'd1);
    chk("t1_rdy",  64'(rdy_s), 64'd1);
    load_words(4, 0, 1'b0, -1, -1);
    send_byte(8'h18, 1'b0);
    chk_end("t1", 1'b0, 4);
    chk("t1_last_data", 64'(wr_data_s), 64'h131415161718);
    chk("t1_last_addr", 64'(wr_addr_s), 64'd3);

    // Restart from DONE, bad checksum
    pulse_start();
    chk("t2_done_clr", 64'(done_s), 64'd0);
    load_words(4, 0, 1'b0, -1, -1);
    send_byte(8'h00, 1'b0);
    chk_end("t2", 1'b1, 8);

    // byte_valid toggling every cycle; err from last load must clear on start
    pulse_start();
    chk("t3_err_clr", 64'(err_s), 64'd0);
    load_words(4, 0, 1'b1, -1, -1);
    send_byte(8'h18, 1'b1);
    chk_end("t3", 1'b0, 12);

    // start pulsed mid-load is ignored
    pulse_start();
    load_words(4, 0, 1'b0, -1, 8);
    send_byte(8'h18, 1'b0);
    chk_end("t4", 1'b0, 16);

    // Reset after 9 accepted bytes
    pulse_start();
    load_words(4, 0, 1'b0, 9, -1);
    RESET = 1'b1;
    #1;
    chk("t5_rdy",   64'(rdy_s), 64'd0);
    chk("t5_busy",  64'(busy_s), 64'd0);
    chk("t5_wr_en", 64'(wr_en_s), 64'd0);
    chk("t5_addr",  64'(wr_addr_s), 64'd0);
    chk("t5_data",  64'(wr_data_s), 64'd0);
    chk("t5_wcnt",  64'(wcnt_s), 64'd17);
    chk("t5_queue", 64'(q_s.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_wr", 64'(wcnt_s), 64'd17);
    pulse_start();
    load_words(4, 0, 1'b0, -1, -1);
    send_byte(8'h18, 1'b0);
    chk_end("t5r", 1'b0, 21);

    // Default-depth instance, random data
    sel = 1'b1;
    pulse_start();
    chk("t6_busy", 64'(busy_l), 64'd1);
    load_words(2048, 1, 1'b0, -1, -1);
    cs = 8'($urandom);
    send_byte(cs, 1'b0);
    chk("t6_wcnt", 64'(wcnt_l), 64'd2048);
    chk("t6_addr", 64'(wr_addr_l), 64'h7FF);
    chk("t6_done", 64'(done_l), 64'd1);
    chk("t6_err",  64'(err_l), 64'(cs != m_xor));
    chk("t6_small_idle", 64'(wcnt_s), 64'd21);
    chk("t6_queue", 64'(q_l.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coef_loader.md
COEF_LOADER -- requirements
Module: coef_loader

Interface
REQ-001 Parameter DEPTH, default 2048, number of 48-bit coefficient words per table load.
REQ-002 Parameter ADDR_W, default 11, write address width; 2^ADDR_W SHALL be >= DEPTH.
REQ-003 Fg_CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a table load.
REQ-006 byte_in  input  8  serial coefficient byte stream.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
REQ-009 wr_en  output  1  one-cycle write strobe to the coefficient RAM.
REQ-010 wr_addr  output  ADDR_W  RAM write address.
REQ-011 wr_data  output  48  packed word; [47:24] sin term, [23:0] cos term.
REQ-012 busy  output  1  high in LOAD and CHECK.
REQ-013 done  output  1  high in DONE (load finished).
REQ-014 err  output  1  checksum mismatch of the last load; valid while done=1.

Function
REQ-015 FSM states: IDLE, LOAD, CHECK, DONE.
REQ-016 IDLE/DONE + start -> LOAD; word address, byte counter (0..5) and running XOR cleared to 0; done and err cleared.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 byte_ready = 1 exactly in LOAD and CHECK; 0 in IDLE and DONE.
REQ-019 Bytes packed MSB first: byte k of a word (k=0..5) lands in wr_data[47-8k:40-8k].
REQ-020 Each accepted LOAD byte SHALL be XORed into the 8-bit running checksum.
REQ-021 On acceptance of byte 5, the following cycle SHALL assert wr_en for exactly one cycle with wr_addr = current word address and the complete packed wr_data; byte counter returns to 0.
REQ-022 Word address increments by 1 after each write; no wrap: after the write at DEPTH-1 the FSM enters CHECK.
REQ-023 Back-to-back bytes (byte_valid held high) SHALL be accepted every cycle; a full load takes 6*DEPTH transfer cycles minimum.
REQ-024 byte_valid gaps SHALL stall the load without loss or duplication.
REQ-025 In CHECK one byte is accepted: err <= (byte_in != running XOR); FSM -> DONE next cycle.
REQ-026 DONE holds done=1 and err until start or RESET.
REQ-027 wr_en SHALL be 0 in every cycle other than those defined in REQ-021.
REQ-028 wr_data and wr_addr SHALL remain stable between writes.

Reset
REQ-029 RESET asserted at any time SHALL immediately force IDLE, wr_en=0, byte_ready=0, busy=0, done=0, err=0, wr_addr=0, wr_data=0, counters and checksum 0.
REQ-030 A load interrupted by RESET SHALL not produce any further write; a new start SHALL restart at address 0.

Verification
REQ-031 DEPTH=4, start, 24 bytes 0x01..0x18 back-to-back, checksum 0x18 -> writes addr0=0x010203040506 ... addr3=0x131415161718, done=1, err=0.
REQ-032 Same stream, checksum byte 0x00 -> done=1, err=1, identical writes.
REQ-033 byte_valid toggled 1/0 every cycle across a load -> same RAM contents as REQ-031, write count = 4.
REQ-034 RESET pulse after 9 accepted bytes -> outputs zeroed immediately, exactly 1 write observed; fresh start reloads from addr 0 correctly.
REQ-035 start pulsed mid-LOAD and in DONE -> ignored mid-LOAD; in DONE clears done/err and restarts at addr 0.
REQ-036 Default DEPTH=2048 full load with random data -> 2048 writes, final wr_addr=0x7FF, err matches reference XOR.
